// File: rtl/cpu_pkg.sv
// cpu_pkg: datapath-wide constants and types shared by the CPU front end.
//   XLEN            - architectural address/data width
//   addr_t          - XLEN-bit address type
//   PC_RESET_VECTOR - fetch address after reset (4-byte aligned)
//   INSTR_BYTES     - size of one instruction word in bytes
package cpu_pkg;

   localparam int XLEN = 32;

   typedef logic [XLEN-1:0] addr_t;

   localparam addr_t PC_RESET_VECTOR = 32'h0000_0000;
   localparam int    INSTR_BYTES     = 4;

endpackage

// File: rtl/pc_incrementer.sv
// pc_incrementer: combinational adder that advances an address by one
// instruction word. Wraps modulo 2^WIDTH; no carry out is produced.
// Ports:
//   pc        in  WIDTH  current address
//   pc_plus4  out WIDTH  pc + INC
module pc_incrementer
   import cpu_pkg::*;
#(
   parameter int WIDTH = XLEN,
   parameter int INC   = INSTR_BYTES
) (
   input  logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus4
);

   assign pc_plus4 = pc + WIDTH'(INC);

endmodule

// File: rtl/program_counter.sv
// program_counter: instruction fetch address register.
// Each rising edge the PC loads pc_in (branch/jump target), holds (stall),
// or advances by one instruction word. pc_load always beats stall.
// Ports:
//   clk         in  1      system clock, rising edge
//   rst_n       in  1      asynchronous active-low reset
//   pc_in       in  WIDTH  next-address value used when pc_load=1
//   pc_load     in  1      select pc_in as next PC
//   stall       in  1      hold PC when pc_load=0
//   pc_out      out WIDTH  current fetch address (registered)
//   pc_plus4    out WIDTH  pc_out + INC (combinational, wraps)
//   misaligned  out 1      sticky: a pc_in with nonzero low bits was loaded
// WIDTH must be at least 3 and RESET_VECTOR must be 4-byte aligned.
module program_counter
   import cpu_pkg::*;
#(
   parameter int               WIDTH        = XLEN,
   parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
   parameter int               INC          = INSTR_BYTES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] pc_in,
   input  logic             pc_load,
   input  logic             stall,
   output logic [WIDTH-1:0] pc_out,
   output logic [WIDTH-1:0] pc_plus4,
   output logic             misaligned
);

   logic [WIDTH-1:0] pc_q;
   logic             misaligned_q;
   logic [WIDTH-1:0] pc_seq;

   // One adder serves both the link-address output and the sequential path.
   pc_incrementer #(
      .WIDTH (WIDTH),
      .INC   (INC)
   ) u_inc (
      .pc       (pc_q),
      .pc_plus4 (pc_seq)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q         <= RESET_VECTOR;
         misaligned_q <= 1'b0;
      end else if (pc_load) begin
         // Targets are forced word-aligned; a dirty target is only flagged.
         pc_q <= {pc_in[WIDTH-1:2], 2'b00};
         if (pc_in[1:0] != 2'b00) begin
            misaligned_q <= 1'b1;
         end
      end else if (!stall) begin
         pc_q <= pc_seq;
      end
   end

   assign pc_out     = pc_q;
   assign pc_plus4   = pc_seq;
   assign misaligned = misaligned_q;

endmodule

// File: tb/tb_program_counter.sv
module tb_program_counter;

   logic        clk;
   logic        rst_n;
   logic [31:0] pc_in;
   logic        pc_load;
   logic        stall;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;
   logic        misaligned;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_q[$];

   program_counter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pc_in      (pc_in),
      .pc_load    (pc_load),
      .stall      (stall),
      .pc_out     (pc_out),
      .pc_plus4   (pc_plus4),
      .misaligned (misaligned)
   );

   // Clock/reset: 10 ns period, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic load, input logic [31:0] addr, input logic hold);
      pc_load = load;
      pc_in   = addr;
      stall   = hold;
   endtask

   // Advance one rising edge, then settle so outputs are sampled off-edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 32'h0, 1'b0);

      #50;
      check("rst_pc", pc_out, 32'h0);
      check("rst_plus4", pc_plus4, 32'h4);
      check("rst_mis", {31'b0, misaligned}, 32'h0);

      #50;
      rst_n = 1'b1;  // t=100, between edges

      // Three sequential increments from the reset vector
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h8);
      exp_q.push_back(32'hC);
      while (exp_q.size() > 0) begin
         tick();
         check("seq_pc", pc_out, exp_q.pop_front());
      end
      check("seq_plus4", pc_plus4, 32'h10);

      // Stall at 0x10, then load overrides stall
      tick();
      check("pre_stall", pc_out, 32'h10);
      drive(1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_hold", pc_out, 32'h10);
      end
      drive(1'b1, 32'h80, 1'b1);
      tick();
      check("load_over_stall", pc_out, 32'h80);

      // Aligned load then increment
      drive(1'b1, 32'h400, 1'b0);
      tick();
      check("load_pc", pc_out, 32'h400);
      check("load_mis", {31'b0, misaligned}, 32'h0);
      drive(1'b0, 32'h0, 1'b0);
      tick();
      check("load_inc", pc_out, 32'h404);

      // Misaligned load is cleaned up and flagged; flag is sticky
      drive(1'b1, 32'h103, 1'b0);
      tick();
      check("mis_pc", pc_out, 32'h100);
      check("mis_flag", {31'b0, misaligned}, 32'h1);
      drive(1'b1, 32'h200, 1'b0);
      tick();
      check("mis_aligned_pc", pc_out, 32'h200);
      check("mis_sticky", {31'b0, misaligned}, 32'h1);

      // Wrap-around at the top of the address space
      drive(1'b1, 32'hFFFF_FFFC, 1'b0);
      tick();
      check("wrap_top", pc_out, 32'hFFFF_FFFC);
      check("wrap_top_plus4", pc_plus4, 32'h0);
      drive(1'b0, 32'h0, 1'b0);
      tick();
      check("wrap_pc", pc_out, 32'h0);
      check("wrap_plus4", pc_plus4, 32'h4);
      check("wrap_mis", {31'b0, misaligned}, 32'h1);

      // Async reset between edges with a load pending
      drive(1'b1, 32'h400, 1'b0);
      tick();
      drive(1'b0, 32'h0, 1'b0);
      tick();
      check("pre_async", pc_out, 32'h404);
      drive(1'b1, 32'h80, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_pc", pc_out, 32'h0);
      check("async_mis", {31'b0, misaligned}, 32'h0);
      tick();
      check("async_hold", pc_out, 32'h0);

      // Release mid-cycle; first edge applies the normal rule
      #2;
      rst_n = 1'b1;
      drive(1'b0, 32'h0, 1'b0);
      tick();
      check("post_rst_pc", pc_out, 32'h4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
